// File: rtl/jam_param.sv
// Job-assignment engine: exhaustive search over all N! worker/job permutations
// for the minimum (Mode=0) or maximum (Mode=1) total cost, using an external
// registered cost ROM addressed by W/J.
module jam_param #(
   parameter int unsigned N      = 8,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned COST_W = 7,
   parameter int unsigned SUM_W  = 10,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Start,
   input  logic                 Mode,
   output logic [IDX_W-1:0]     W,
   output logic [IDX_W-1:0]     J,
   input  logic [COST_W-1:0]    Cost,
   output logic                 Busy,
   output logic                 Valid,
   output logic [SUM_W-1:0]     MinCost,
   output logic [CNT_W-1:0]     MatchCount,
   output logic [N*IDX_W-1:0]   BestPerm
);

   localparam int unsigned ACNT_W = $clog2(N + 2);
   localparam int          NI     = int'(N);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC, S_CMP, S_NEXT, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [ACNT_W-1:0]   acnt;
   logic [SUM_W-1:0]    sum, best;
   logic [CNT_W-1:0]    count;
   logic                mode_q;
   logic [IDX_W-1:0]    perm      [N];
   logic [IDX_W-1:0]    best_perm [N];
   logic [IDX_W-1:0]    perm_nxt  [N];
   logic [IDX_W-1:0]    swp       [N];
   logic [IDX_W-1:0]    pi, pk, j_sel;
   int                  i_idx, k_idx;
   logic                last_perm, better, equal;

   // Lexicographic successor of perm; last_perm flags a fully descending perm
   always_comb begin
      last_perm = 1'b1;
      i_idx     = 0;
      k_idx     = 0;
      pi        = '0;
      pk        = '0;
      for (int m = 0; m < NI - 1; m++) begin
         if (perm[m] < perm[m+1]) begin
            i_idx     = m;
            last_perm = 1'b0;
         end
      end
      for (int m = 0; m < NI; m++) begin
         if (m == i_idx) pi = perm[m];
      end
      for (int m = 0; m < NI; m++) begin
         if (m > i_idx && perm[m] > pi) begin
            k_idx = m;
            pk    = perm[m];
         end
      end
      for (int m = 0; m < NI; m++) begin
         swp[m] = perm[m];
         if (m == i_idx) swp[m] = pk;
         if (m == k_idx) swp[m] = pi;
      end
      for (int j = 0; j < NI; j++) begin
         perm_nxt[j] = swp[j];
         if (j > i_idx) begin
            for (int m = 0; m < NI; m++) begin
               if (m + j == NI + i_idx) perm_nxt[j] = swp[m];
            end
         end
      end
   end

   // Job index for the worker currently being addressed, and compare results
   always_comb begin
      j_sel = '0;
      for (int m = 0; m < NI; m++) begin
         if (acnt == ACNT_W'(m)) j_sel = perm[m];
      end
      better = mode_q ? (sum > best) : (sum < best);
      equal  = (sum == best);
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (Start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_ACC;
         S_ACC:   if (acnt == ACNT_W'(N + 1)) state_nxt = S_CMP;
         S_CMP:   state_nxt = S_NEXT;
         S_NEXT:  state_nxt = last_perm ? S_DONE : S_ACC;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: address issue, cost accumulation (ROM latency of two edges), compare, permute
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         W          <= '0;
         J          <= '0;
         Busy       <= 1'b0;
         Valid      <= 1'b0;
         MinCost    <= '0;
         MatchCount <= '0;
         BestPerm   <= '0;
         acnt       <= '0;
         sum        <= '0;
         best       <= '0;
         count      <= '0;
         mode_q     <= 1'b0;
         for (int m = 0; m < NI; m++) begin
            perm[m]      <= IDX_W'(m);
            best_perm[m] <= IDX_W'(m);
         end
      end else begin
         Valid <= (state_nxt == S_DONE);
         Busy  <= (state_nxt != S_IDLE);
         W     <= '0;
         J     <= '0;
         case (state)
            S_IDLE: begin
               if (Start) mode_q <= Mode;
            end
            S_LOAD: begin
               for (int m = 0; m < NI; m++) begin
                  perm[m]      <= IDX_W'(m);
                  best_perm[m] <= IDX_W'(m);
               end
               best  <= mode_q ? '0 : '1;
               count <= '0;
               sum   <= '0;
               acnt  <= '0;
            end
            S_ACC: begin
               acnt <= acnt + ACNT_W'(1);
               if (acnt < ACNT_W'(N)) begin
                  W <= IDX_W'(acnt);
                  J <= j_sel;
               end
               if (acnt >= ACNT_W'(2)) sum <= sum + SUM_W'(Cost);
            end
            S_CMP: begin
               if (better) begin
                  best      <= sum;
                  count     <= CNT_W'(1);
                  best_perm <= perm;
               end else if (equal && count != '1) begin
                  count <= count + CNT_W'(1);
               end
            end
            S_NEXT: begin
               sum  <= '0;
               acnt <= '0;
               if (last_perm) begin
                  MinCost    <= best;
                  MatchCount <= count;
                  for (int m = 0; m < NI; m++) BestPerm[m*IDX_W +: IDX_W] <= best_perm[m];
               end else begin
                  perm <= perm_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
